instr_mem_loadable: RTL and testbench
=====================================

Name: instr_mem_loadable

Overview:
Parametrised, byte-addressed, little-endian instruction memory with a registered fetch port and a byte-serial programming port.
- Replaces a fixed, hard-initialised, combinational program store, so test programs can be streamed in at run time instead of being compiled into the RTL.
- Sits between the boot/test loader and the processor fetch stage.
- Mode FSM: RUN (fetch allowed) and LOAD (programming).

Parameters:
ADDR_W, 8, byte-address width; depth = 2**ADDR_W bytes.
WORD_BYTES, 4, bytes per instruction word; power of two, ≤ 2**ADDR_W; DATA_W = 8*WORD_BYTES.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
load_start  in  1  one-cycle pulse: enter LOAD, pointer := load_base
load_base  in  ADDR_W  start byte address for load, sampled with load_start
load_byte_valid  in  1  load_byte is valid this cycle
load_byte  in  8  programming data byte
load_done  in  1  one-cycle pulse: leave LOAD, return to RUN
busy  out  1  high while in LOAD
load_count  out  ADDR_W+1  bytes written since last load_start
load_ovf  out  1  sticky: byte offered after pointer passed top of memory
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_W  fetch byte address
fetch_rdata  out  DATA_W  little-endian word; byte at fetch_addr is in the LSBs
fetch_valid  out  1  response strobe, one cycle
fetch_err  out  1  response is an error, qualified by fetch_valid

Behaviour:
- Reset (async, rst_n=0): state=RUN; busy=0, load_count=0, load_ovf=0, fetch_valid=0, fetch_err=0, fetch_rdata=0, pointer=0, pointer-exhausted flag=0.
- Memory array is not reset; contents survive rst_n.
- FSM, RUN→LOAD: on load_start. Also: pointer:=load_base, load_count:=0, load_ovf:=0, exhausted flag cleared.
- FSM, LOAD→RUN: on load_done.
- FSM, load_start and load_done in the same cycle: load_start wins (enter or stay in LOAD, re-init pointer).
- load_start while already in LOAD: re-initialises pointer/count/ovf; memory is untouched.
- Load write (LOAD, load_byte_valid=1, not exhausted): mem[pointer]:=load_byte; load_count++.
  - pointer++ if pointer ≠ 2**ADDR_W−1.
  - Else set the exhausted flag; pointer never wraps.
- Load write while exhausted: byte dropped; load_ovf:=1.
- The load_byte_valid byte in a load_start cycle is ignored.
- The load_byte_valid byte in a load_done cycle is written, then the FSM returns to RUN.
- load_byte_valid in RUN: ignored, no state change.
- Fetch latency: exactly 1 cycle. Request sampled at edge N; fetch_valid/fetch_err/fetch_rdata are registered and visible after edge N. fetch_valid=0 on cycles without a request.
- Throughput: one request per cycle, fully pipelined, no stall.
- Fetch error cases (fetch_valid=1, fetch_err=1, fetch_rdata=0):
  - fetch_addr[log2(WORD_BYTES)-1:0] ≠ 0 (misaligned);
  - request made while in LOAD, including the load_start cycle.
- Fetch on the load_done cycle is still an error; the first legal fetch is the cycle after load_done.
- Successful fetch: fetch_rdata = {mem[a+WB-1],…,mem[a+1],mem[a]}, fetch_err=0. No out-of-range case exists, since aligned words always fit.
- fetch_rdata holds its last value when fetch_valid=0.
- Reset mid-load: FSM to RUN. Bytes already written remain in memory; unwritten bytes keep their old contents.

Test Plan:
- Load then fetch: load_start base 0x00; bytes 0x04,0x00,0x10,0xE4; load_done; fetch 0x00 → next cycle fetch_valid=1, err=0, rdata=0xE4100004; load_count=4.
- Misaligned fetch: fetch 0x02 → fetch_valid=1, fetch_err=1, rdata=0. Fetch during LOAD (busy=1) → same error response.
- Back-to-back fetches: 0x00,0x04,0x08 on consecutive cycles after loading 12 bytes → three consecutive valid responses, in order, matching the loaded words.
- Top-of-memory overflow: base 0xFC, six bytes 0x11..0x16.
  - load_count=4 and load_ovf=1 after byte 5.
  - fetch 0xFC → 0x14131211.
  - next load_start clears load_ovf.
- Reset mid-load: base 0x10, bytes 0xAA,0xBB, assert rst_n=0.
  - busy=0, load_count=0.
  - fetch 0x10 → bytes 0..1 = 0xBBAA, upper bytes unchanged.
- Simultaneous pulses: load_start+load_done same cycle → busy=1. Byte with load_done → written, busy=0 next cycle.

Source files
------------

// File: rtl/instr_mem_loadable_if.sv
// Loader/fetch bus of the loadable instruction memory.
// master = boot loader + fetch stage, slave = memory.
interface instr_mem_loadable_if #(
    parameter int ADDR_W     = 8,
    parameter int WORD_BYTES = 4
);
    localparam int DATA_W = 8 * WORD_BYTES;

    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic              load_byte_valid;
    logic [7:0]        load_byte;
    logic              load_done;
    logic              busy;
    logic [ADDR_W:0]   load_count;
    logic              load_ovf;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_rdata;
    logic              fetch_valid;
    logic              fetch_err;

    modport master (
        output load_start, load_base, load_byte_valid, load_byte, load_done,
        output fetch_req, fetch_addr,
        input  busy, load_count, load_ovf,
        input  fetch_rdata, fetch_valid, fetch_err
    );

    modport slave (
        input  load_start, load_base, load_byte_valid, load_byte, load_done,
        input  fetch_req, fetch_addr,
        output busy, load_count, load_ovf,
        output fetch_rdata, fetch_valid, fetch_err
    );
endinterface

// File: rtl/instr_mem_loadable.sv
// Byte-addressed little-endian instruction memory: byte-serial LOAD port,
// single-cycle registered word fetch port in RUN.
module instr_mem_loadable #(
    parameter int ADDR_W     = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_mem_loadable_if.slave  bus
);
    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

    typedef enum logic {RUN, LOAD} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              exhausted;
    logic [ADDR_W:0]   load_count;
    logic              load_ovf;
    logic [7:0]        mem [DEPTH];

    logic              fetch_valid_p1;
    logic              fetch_err_p1;
    logic [DATA_W-1:0] fetch_rdata_p1;

    logic              wr_en;
    logic              fetch_bad;
    logic [DATA_W-1:0] rd_word;

    function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
        return (addr & ADDR_W'(WORD_BYTES - 1)) != '0;
    endfunction

    // Bytes of a load_start cycle are discarded; the load_done cycle still writes.
    assign wr_en     = (state == LOAD) && !bus.load_start && bus.load_byte_valid && !exhausted;
    assign fetch_bad = (state == LOAD) || bus.load_start || misaligned(bus.fetch_addr);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rd_word[8*i +: 8] = mem[ADDR_W'(bus.fetch_addr + ADDR_W'(i))];
        end
    end

    // Program store is deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr] <= bus.load_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            ptr            <= '0;
            exhausted      <= 1'b0;
            load_count     <= '0;
            load_ovf       <= 1'b0;
            fetch_valid_p1 <= 1'b0;
            fetch_err_p1   <= 1'b0;
            fetch_rdata_p1 <= '0;
        end else begin
            fetch_valid_p1 <= bus.fetch_req;
            fetch_err_p1   <= bus.fetch_req && fetch_bad;
            if (bus.fetch_req) begin
                fetch_rdata_p1 <= fetch_bad ? '0 : rd_word;
            end

            if (bus.load_start) begin
                state      <= LOAD;
                ptr        <= bus.load_base;
                exhausted  <= 1'b0;
                load_count <= '0;
                load_ovf   <= 1'b0;
            end else if (state == LOAD) begin
                if (bus.load_byte_valid) begin
                    if (exhausted) begin
                        load_ovf <= 1'b1;
                    end else begin
                        load_count <= load_count + 1'b1;
                        // Pointer parks at the top byte instead of wrapping to 0.
                        if (ptr == TOP_ADDR) begin
                            exhausted <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                if (bus.load_done) begin
                    state <= RUN;
                end
            end
        end
    end

    // ---- p1: registered response stage ----
    assign bus.busy        = (state == LOAD);
    assign bus.load_count  = load_count;
    assign bus.load_ovf    = load_ovf;
    assign bus.fetch_valid = fetch_valid_p1;
    assign bus.fetch_err   = fetch_err_p1;
    assign bus.fetch_rdata = fetch_rdata_p1;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Randomised + directed bench for instr_mem_loadable against an
// address-arithmetic reference model of the load/fetch rules.
module tb_instr_mem_loadable;
    localparam int AW    = 8;
    localparam int WB    = 4;
    localparam int DEPTH = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    instr_mem_loadable_if #(.ADDR_W(AW), .WORD_BYTES(WB)) bus();

    instr_mem_loadable #(.ADDR_W(AW), .WORD_BYTES(WB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a load session is (base, accepted bytes); the target
    // address of the next byte is base + accepted, writable while < DEPTH.
    logic [7:0]  mm [DEPTH];
    bit          m_load  = 0;
    int          m_base  = 0;
    int          m_count = 0;
    bit          m_ovf   = 0;
    bit          m_valid = 0;
    bit          m_err   = 0;
    logic [31:0] m_rdata = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_load = 0; m_base = 0; m_count = 0; m_ovf = 0;
            m_valid = 0; m_err = 0; m_rdata = '0;
        end else begin
            m_valid = bus.fetch_req;
            m_err   = 0;
            if (bus.fetch_req) begin
                if (m_load || bus.load_start || (int'(bus.fetch_addr) % WB) != 0) begin
                    m_err = 1; m_rdata = '0;
                end else begin
                    for (int k = 0; k < WB; k++)
                        m_rdata[8*k +: 8] = mm[int'(bus.fetch_addr) + k];
                end
            end
            if (bus.load_start) begin
                m_load = 1; m_base = int'(bus.load_base); m_count = 0; m_ovf = 0;
            end else if (m_load) begin
                if (bus.load_byte_valid) begin
                    if (m_base + m_count < DEPTH) begin
                        mm[m_base + m_count] = bus.load_byte;
                        m_count++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (bus.load_done) m_load = 0;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("busy",        64'(bus.busy),        64'(m_load));
            chk("load_count",  64'(bus.load_count),  64'(m_count));
            chk("load_ovf",    64'(bus.load_ovf),    64'(m_ovf));
            chk("fetch_valid", 64'(bus.fetch_valid), 64'(m_valid));
            chk("fetch_rdata", 64'(bus.fetch_rdata), 64'(m_rdata));
            if (m_valid) chk("fetch_err", 64'(bus.fetch_err), 64'(m_err));
        end
    end

    task automatic cyc(input logic ls, input logic [7:0] base, input logic bv,
                       input logic [7:0] b, input logic ld, input logic fr,
                       input logic [7:0] fa);
        bus.load_start      = ls;
        bus.load_base       = base;
        bus.load_byte_valid = bv;
        bus.load_byte       = b;
        bus.load_done       = ld;
        bus.fetch_req       = fr;
        bus.fetch_addr      = fa;
        @(posedge clk);
        #1;
        bus.load_start = 0; bus.load_byte_valid = 0; bus.load_done = 0; bus.fetch_req = 0;
    endtask

    task automatic do_start(input logic [7:0] base); cyc(1, base, 0, 0, 0, 0, 0); endtask
    task automatic do_byte(input logic [7:0] b);     cyc(0, 0, 1, b, 0, 0, 0);    endtask
    task automatic do_done();                        cyc(0, 0, 0, 0, 1, 0, 0);    endtask
    task automatic do_fetch(input logic [7:0] a);    cyc(0, 0, 0, 0, 0, 1, a);    endtask

    logic [7:0] bytes12 [12];
    logic [7:0] save12, save13;

    initial begin
        bus.load_start = 0; bus.load_base = 0; bus.load_byte_valid = 0; bus.load_byte = 0;
        bus.load_done = 0; bus.fetch_req = 0; bus.fetch_addr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   64'(bus.busy),        64'd0);
        chk("reset_count",  64'(bus.load_count),  64'd0);
        chk("reset_valid",  64'(bus.fetch_valid), 64'd0);
        chk("reset_rdata",  64'(bus.fetch_rdata), 64'd0);
        rst_n = 1'b1;

        // Fill the whole array so every later fetch has known contents.
        do_start(8'h00);
        for (int i = 0; i < DEPTH; i++)
            cyc(0, 0, 1, 8'($urandom), (i == DEPTH - 1), 0, 0);
        chk("fill_busy",  64'(bus.busy),       64'd0);
        chk("fill_count", 64'(bus.load_count), 64'd256);
        chk("fill_ovf",   64'(bus.load_ovf),   64'd0);

        // Basic load then fetch
        do_start(8'h00);
        do_byte(8'h04); do_byte(8'h00); do_byte(8'h10); do_byte(8'hE4);
        do_done();
        do_fetch(8'h00);
        chk("lf_valid", 64'(bus.fetch_valid), 64'd1);
        chk("lf_err",   64'(bus.fetch_err),   64'd0);
        chk("lf_rdata", 64'(bus.fetch_rdata), 64'hE4100004);
        chk("lf_count", 64'(bus.load_count),  64'd4);

        // Error responses
        do_fetch(8'h02);
        chk("mis_err",   64'(bus.fetch_err),   64'd1);
        chk("mis_rdata", 64'(bus.fetch_rdata), 64'd0);
        cyc(1, 8'h40, 0, 0, 0, 1, 8'h00);
        chk("start_fetch_err", 64'(bus.fetch_err), 64'd1);
        do_fetch(8'h04);
        chk("load_fetch_busy", 64'(bus.busy),      64'd1);
        chk("load_fetch_err",  64'(bus.fetch_err), 64'd1);
        cyc(0, 0, 0, 0, 1, 1, 8'h00);
        chk("done_fetch_err",  64'(bus.fetch_err), 64'd1);

        // Back-to-back fetches
        for (int i = 0; i < 12; i++) bytes12[i] = 8'($urandom);
        do_start(8'h00);
        for (int i = 0; i < 12; i++) do_byte(bytes12[i]);
        do_done();
        bus.fetch_req = 1; bus.fetch_addr = 8'h00;
        for (int w = 0; w < 3; w++) begin
            @(posedge clk); #1;
            chk("b2b_valid", 64'(bus.fetch_valid), 64'd1);
            chk("b2b_rdata", 64'(bus.fetch_rdata),
                64'({bytes12[4*w+3], bytes12[4*w+2], bytes12[4*w+1], bytes12[4*w]}));
            bus.fetch_addr = 8'(4 * (w + 1));
        end
        bus.fetch_req = 0;

        // Top-of-memory overflow
        do_start(8'hFC);
        for (int i = 0; i < 5; i++) do_byte(8'(8'h11 + i));
        chk("ovf_count", 64'(bus.load_count), 64'd4);
        chk("ovf_flag",  64'(bus.load_ovf),   64'd1);
        do_byte(8'h16);
        do_done();
        do_fetch(8'hFC);
        chk("ovf_rdata", 64'(bus.fetch_rdata), 64'h14131211);
        do_start(8'h80);
        chk("ovf_clear", 64'(bus.load_ovf), 64'd0);
        do_done();

        // Reset in the middle of a load
        save12 = mm[8'h12]; save13 = mm[8'h13];
        do_start(8'h10);
        do_byte(8'hAA); do_byte(8'hBB);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_busy",  64'(bus.busy),       64'd0);
        chk("mrst_count", 64'(bus.load_count), 64'd0);
        rst_n = 1'b1;
        do_fetch(8'h10);
        chk("mrst_rdata", 64'(bus.fetch_rdata), 64'({save13, save12, 8'hBB, 8'hAA}));

        // Simultaneous start/done, byte written on load_done
        cyc(1, 8'h20, 0, 0, 1, 0, 0);
        chk("sim_busy", 64'(bus.busy), 64'd1);
        cyc(0, 0, 1, 8'h5A, 1, 0, 0);
        chk("done_busy",  64'(bus.busy),       64'd0);
        chk("done_count", 64'(bus.load_count), 64'd1);
        do_fetch(8'h20);
        chk("done_byte", 64'(bus.fetch_rdata[7:0]), 64'h5A);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] fa;
            logic [7:0] base;
            fa   = 8'($urandom);
            if ($urandom_range(3) != 0) fa = fa & 8'hFC;
            base = 8'($urandom);
            if ($urandom_range(3) == 0) base = base | 8'hF0;
            cyc(($urandom_range(19) == 0), base, 1'($urandom), 8'($urandom),
                ($urandom_range(7) == 0), ($urandom_range(2) != 0), fa);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
